// File: rtl/mips32_boot_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips32_boot_pkg : boot controller state encoding and REGINIT-skip constant
// Rev 1.0 : initial release (REGINIT controlled by MIPS32_BOOT_REGINIT_EN)
// ---------------------------------------------------------------------------
package mips32_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_REGINIT = 3'd2,
        ST_RUN     = 3'd3,
        ST_CHK_RD  = 3'd4,
        ST_CHK_CMP = 3'd5,
        ST_DONE    = 3'd6
    } boot_state_t;

`ifdef MIPS32_BOOT_REGINIT_EN
    localparam bit C_REGINIT_SKIP = 1'b0;
`else
    localparam bit C_REGINIT_SKIP = 1'b1;
`endif

endpackage
`default_nettype wire

// File: rtl/mips32_boot_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips32_boot_watchdog : saturating RUN-cycle counter and timeout-limit compare
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module mips32_boot_watchdog #(
    parameter int CYC_W = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             count_i,
    input  logic [CYC_W-1:0] lim_i,
    output logic [CYC_W-1:0] cycles_o,
    output logic             expire_o
);

    logic [CYC_W-1:0] cycles_q;
    logic [CYC_W-1:0] cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (clear_i) begin
            cycles_d = '0;
        end else if (count_i && (cycles_q != {CYC_W{1'b1}})) begin
            cycles_d = cycles_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    // A zero limit disables expiry; a saturated count wraps the +1 to 0 and never matches.
    assign expire_o = count_i && (lim_i != '0) && ((cycles_q + CYC_W'(1)) == lim_i);
    assign cycles_o = cycles_q;

endmodule
`default_nettype wire

// File: rtl/mips32_boot_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips32_boot_ctrl : load image, optionally seed registers, run core, check result
// Rev 1.0 : initial release (register seeding under MIPS32_BOOT_REGINIT_EN)
// ---------------------------------------------------------------------------
module mips32_boot_ctrl
    import mips32_boot_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int CYC_W    = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              reg_we_o,
    output logic [REG_AW-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              core_run_o,
    input  logic              core_halted_i,
    input  logic [CYC_W-1:0]  timeout_lim_i,
    input  logic [ADDR_W-1:0] chk_addr_i,
    input  logic [DATA_W-1:0] chk_expect_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [CYC_W-1:0]  cycles_o
);

    if ((2 ** REG_AW) < NUM_REGS) begin : g_cfg_check
        $error("mips32_boot_ctrl: REG_AW too narrow for NUM_REGS");
    end

    boot_state_t state_q, state_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic        w_expire;
    logic        w_wd_clear;
    logic        w_wd_count;

`ifdef MIPS32_BOOT_REGINIT_EN
    logic [REG_AW-1:0] reg_cnt_q, reg_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        ld_ready_o  = 1'b0;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        core_run_o  = 1'b0;
`ifdef MIPS32_BOOT_REGINIT_EN
        reg_cnt_d   = reg_cnt_q;
        reg_we_o    = 1'b0;
        reg_waddr_o = '0;
        reg_wdata_o = '0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_LOAD;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_LOAD: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    mem_we_o    = 1'b1;
                    mem_addr_o  = ld_addr_i;
                    mem_wdata_o = ld_data_i;
                    if (ld_last_i) begin
                        state_d = C_REGINIT_SKIP ? ST_RUN : ST_REGINIT;
                    end
                end
            end
`ifdef MIPS32_BOOT_REGINIT_EN
            ST_REGINIT: begin
                reg_we_o    = 1'b1;
                reg_waddr_o = reg_cnt_q;
                reg_wdata_o = DATA_W'(reg_cnt_q);
                if (reg_cnt_q == REG_AW'(NUM_REGS - 1)) begin
                    reg_cnt_d = '0;
                    state_d   = ST_RUN;
                end else begin
                    reg_cnt_d = reg_cnt_q + REG_AW'(1);
                end
            end
`endif
            ST_RUN: begin
                core_run_o = 1'b1;
                // Halt takes priority over a watchdog expiry in the same cycle.
                if (core_halted_i) begin
                    state_d = ST_CHK_RD;
                end else if (w_expire) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            ST_CHK_RD: begin
                mem_re_o   = 1'b1;
                mem_addr_o = chk_addr_i;
                state_d    = ST_CHK_CMP;
            end
            ST_CHK_CMP: begin
                pass_d  = (mem_rdata_i == chk_expect_i);
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifndef MIPS32_BOOT_REGINIT_EN
    assign reg_we_o    = 1'b0;
    assign reg_waddr_o = '0;
    assign reg_wdata_o = '0;
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef MIPS32_BOOT_REGINIT_EN
            reg_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
`ifdef MIPS32_BOOT_REGINIT_EN
            reg_cnt_q <= reg_cnt_d;
`endif
        end
    end

    assign w_wd_count = (state_q == ST_RUN);
    assign w_wd_clear = (state_q != ST_RUN) && (state_d == ST_RUN);

    mips32_boot_watchdog #(
        .CYC_W (CYC_W)
    ) u_watchdog (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .clear_i  (w_wd_clear),
        .count_i  (w_wd_count),
        .lim_i    (timeout_lim_i),
        .cycles_o (cycles_o),
        .expire_o (w_expire)
    );

    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o    = (state_q == ST_DONE);
    assign pass_o    = pass_q;
    assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mips32_boot_ctrl.sv
`default_nettype none
// tb_mips32_boot_ctrl : directed + randomized boots against a reference memory and timing model.
module tb_mips32_boot_ctrl;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 10;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int CYC_W    = 16;

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              reg_we;
    logic [REG_AW-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic              core_run;
    logic              core_halted = 1'b0;
    logic [CYC_W-1:0]  timeout_lim = '0;
    logic [ADDR_W-1:0] chk_addr = '0;
    logic [DATA_W-1:0] chk_expect = '0;
    logic              busy, done, pass, timeout;
    logic [CYC_W-1:0]  cycles;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] mem [0:1023];
    logic              core_wr_en = 1'b0;
    logic [ADDR_W-1:0] core_wr_addr = '0;
    logic [DATA_W-1:0] core_wr_data = '0;

    logic [DATA_W-1:0]        ref_mem [int];
    logic [ADDR_W-1:0]        bq_addr [$];
    logic [DATA_W-1:0]        bq_data [$];
    logic [ADDR_W+DATA_W-1:0] wlog    [$];

    mips32_boot_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .CYC_W(CYC_W)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .start_i(start),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr),
        .ld_data_i(ld_data), .ld_last_i(ld_last),
        .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
        .core_run_o(core_run), .core_halted_i(core_halted), .timeout_lim_i(timeout_lim),
        .chk_addr_i(chk_addr), .chk_expect_i(chk_expect),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout), .cycles_o(cycles)
    );

    always #5 clk1 = ~clk1;

    // Unified memory the controller and the stand-in core share.
    always @(posedge clk1) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (core_wr_en) mem[core_wr_addr] <= core_wr_data;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk1) begin
        if (rst_n && mem_we) wlog.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout observed=stuck required=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fact(input logic [31:0] n);
        logic [31:0] p = 32'd1;
        for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
        return p;
    endfunction

    task automatic gen_beats(input int n);
        bq_addr.delete();
        bq_data.delete();
        for (int i = 0; i < n; i++) begin
            bq_addr.push_back(ADDR_W'($urandom_range(0, 1023)));
            bq_data.push_back($urandom);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ld_ready", ld_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_pass_clr", pass, 0);
        chk("start_to_clr", timeout, 0);
    endtask

    // mode 0: every cycle valid, 1: valid every other cycle, 2: random gaps
    task automatic load_image(input int mode);
        int  idx = 0;
        int  cyc = 0;
        bit  v;
        int  n = bq_addr.size();
        wlog.delete();
        while (idx < n && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 1);
                default: v = bit'($urandom_range(0, 1));
            endcase
            ld_valid = v;
            ld_addr  = v ? bq_addr[idx] : ADDR_W'($urandom);
            ld_data  = v ? bq_data[idx] : $urandom;
            ld_last  = v ? (idx == n - 1) : bit'($urandom_range(0, 1));
            #1;
            chk("ld_ready", ld_ready, 1);
            chk("ld_we", mem_we, v);
            chk("ld_core_run", core_run, 0);
            chk("ld_reg_we", reg_we, 0);
            if (v) begin
                chk("ld_addr", mem_addr, bq_addr[idx]);
                chk("ld_wdata", mem_wdata, bq_data[idx]);
                ref_mem[int'(bq_addr[idx])] = bq_data[idx];
            end
            step();
            if (v) idx++;
            cyc++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("ld_beats", idx, n);
        chk("ld_we_pulses", wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            chk("ld_log", wlog[i], {bq_addr[i], bq_data[i]});
        end
    endtask

    task automatic reginit_phase();
`ifdef MIPS32_BOOT_REGINIT_EN
        for (int k = 0; k < NUM_REGS; k++) begin
            chk("ri_we", reg_we, 1);
            chk("ri_waddr", reg_waddr, k);
            chk("ri_wdata", reg_wdata, k);
            chk("ri_core_run", core_run, 0);
            step();
        end
`endif
    endtask

    // Stand-in core halts after halt_at RUN cycles; the reference decides who wins.
    task automatic run_phase(input int halt_at, input logic [CYC_W-1:0] lim, input bit do_result);
        bit          exp_to;
        int          exp_n;
        int          n = 0;
        logic        exp_pass;
        timeout_lim = lim;
        exp_to = (lim != 0) && (int'(lim) <= halt_at);
        exp_n  = exp_to ? int'(lim) : halt_at + 1;
        if (do_result) ref_mem[int'(chk_addr)] = fact(ref_mem[200]);
        exp_pass = !exp_to && (ref_mem[int'(chk_addr)] == chk_expect);
        chk("run_entry", core_run, 1);
        while (core_run === 1'b1 && n < 3000) begin
            core_halted = (n == halt_at);
            start       = (n == 1);
            if (do_result && n == halt_at) begin
                core_wr_en   = 1'b1;
                core_wr_addr = chk_addr;
                core_wr_data = fact(mem[200]);
            end
            step();
            core_halted = 1'b0;
            core_wr_en  = 1'b0;
            start       = 1'b0;
            n++;
        end
        chk("run_len", n, exp_n);
        if (!exp_to) begin
            chk("chkrd_re", mem_re, 1);
            chk("chkrd_addr", mem_addr, chk_addr);
            chk("chkrd_done", done, 0);
            step();
            chk("chkcmp_re", mem_re, 0);
            chk("chkcmp_busy", busy, 1);
            step();
        end
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_timeout", timeout, exp_to);
        chk("fin_pass", pass, exp_pass);
        chk("fin_cycles", cycles, exp_n);
        chk("fin_core_run", core_run, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_re"}, mem_re, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_reg_we"}, reg_we, 0);
        chk({tag, "_reg_waddr"}, reg_waddr, 0);
        chk({tag, "_reg_wdata"}, reg_wdata, 0);
        chk({tag, "_core_run"}, core_run, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_cycles"}, cycles, 0);
    endtask

    initial begin
        int sel;
        logic [31:0] fact_img [8];
        fact_img = '{32'h280a00c8, 32'h28020001, 32'h21430000, 32'h14431000,
                     32'h2c630001, 32'h3460fffd, 32'h2542fffe, 32'hfc000000};

        // Reset
        step();
        step();
        chk_idle_outputs("rst");
        rst_n = 1'b1;
        step();
        chk_idle_outputs("idle");
        ld_valid = 1'b1;
        #1;
        chk("idle_ld_ignored", mem_we, 0);
        ld_valid = 1'b0;
        step();

        // Factorial image
        bq_addr.delete();
        bq_data.delete();
        for (int i = 0; i < 8; i++) begin
            bq_addr.push_back(ADDR_W'(i));
            bq_data.push_back(fact_img[i]);
        end
        bq_addr.push_back(ADDR_W'(200));
        bq_data.push_back(32'd10);
        chk_addr   = ADDR_W'(198);
        chk_expect = 32'd3628800;
        pulse_start();
        load_image(0);
        reginit_phase();
        run_phase(int'($urandom_range(20, 60)), '0, 1'b1);
        ld_valid = 1'b1;
        #1;
        chk("done_ld_ignored", mem_we, 0);
        chk("done_ld_ready", ld_ready, 0);
        ld_valid = 1'b0;
        step();

        // Loader backpressure
        gen_beats(5);
        pulse_start();
        load_image(1);
        sel = int'($urandom_range(0, 4));
        chk_addr   = bq_addr[sel];
        chk_expect = ref_mem[int'(chk_addr)];
        reginit_phase();
        run_phase(5, '0, 1'b0);

        // Mismatch
        gen_beats(3);
        pulse_start();
        load_image(2);
        chk_addr   = bq_addr[1];
        chk_expect = ref_mem[int'(chk_addr)] + 32'd1;
        reginit_phase();
        run_phase(7, CYC_W'(50), 1'b0);

        // Watchdog expiry at 100, then disabled watchdog for 1000+ cycles
        gen_beats(1);
        pulse_start();
        load_image(0);
        chk_addr   = bq_addr[0];
        chk_expect = ref_mem[int'(chk_addr)];
        reginit_phase();
        run_phase(100000, CYC_W'(100), 1'b0);
        pulse_start();
        load_image(2);
        reginit_phase();
        run_phase(1000, '0, 1'b0);

        // Halt in the expiry cycle
        sel = int'($urandom_range(2, 40));
        pulse_start();
        load_image(0);
        reginit_phase();
        run_phase(sel - 1, CYC_W'(sel), 1'b0);

        // Randomized boots
        for (int r = 0; r < 4; r++) begin
            gen_beats(int'($urandom_range(1, 6)));
            pulse_start();
            load_image(2);
            chk_addr   = bq_addr[$urandom_range(0, bq_addr.size() - 1)];
            chk_expect = ref_mem[int'(chk_addr)] ^ {31'd0, 1'($urandom_range(0, 1))};
            reginit_phase();
            run_phase(int'($urandom_range(0, 40)),
                      ($urandom_range(0, 1) == 1) ? CYC_W'(0) : CYC_W'($urandom_range(1, 40)),
                      1'b0);
        end

        // Reset in the middle of RUN, then a clean reboot
        gen_beats(2);
        pulse_start();
        load_image(0);
        reginit_phase();
        timeout_lim = '0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_run", core_run, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_core_run", core_run, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cycles", cycles, 0);
        step();
        rst_n = 1'b1;
        step();
        chk_idle_outputs("post_rst");
        gen_beats(4);
        pulse_start();
        load_image(2);
        chk_addr   = bq_addr[3];
        chk_expect = ref_mem[int'(chk_addr)];
        reginit_phase();
        run_phase(3, CYC_W'(20), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
